alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameters: WORD=32 (operand width), ADDR_W=5 (register address width), TAG_W=2 (producer tag width), OP_W=6 (opcode width), DEPTH=4 (entries).
REQ-002 SHALL use tag encodings UNLOCKED=0, ALU_MASTER=1, ALU_SALVER=2, LOAD_STORE=3; write bus k carries results of producer tag k+1.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rdy  in  1  global enable; when low, all state SHALL hold.
REQ-006 disp_en  in  1  dispatch request.
REQ-007 disp_op  in  OP_W  ALU opcode.
REQ-008 disp_rd  in  ADDR_W  destination register.
REQ-009 disp_datax / disp_datay  in  WORD  operand values from register status.
REQ-010 disp_tagx / disp_tagy  in  TAG_W  operand tags; UNLOCKED means value valid.
REQ-011 disp_addrx / disp_addry  in  ADDR_W  operand source registers.
REQ-012 en_wk, addr_wk, data_wk (k=0..2)  in  1/ADDR_W/WORD  result write buses.
REQ-013 full  out  1  all DEPTH entries occupied.
REQ-014 iss_valid  out  1  issue candidate present; iss_ready  in  1  ALU accepts.
REQ-015 iss_op / iss_rd / iss_x / iss_y  out  OP_W/ADDR_W/WORD/WORD  issued instruction.

Function
REQ-016 Each entry SHALL hold: busy, op, rd, and per operand {data, tag, addr}.
REQ-017 full SHALL be combinational: high iff all entries busy.
REQ-018 Dispatch SHALL be accepted at the edge when rdy && disp_en && !full, writing the lowest-index non-busy entry.
REQ-019 disp_en while full SHALL be ignored with no state change.
REQ-020 Wakeup: a busy operand with tag T!=UNLOCKED SHALL capture data_wk and set tag UNLOCKED when en_wk, k+1==T, addr_wk==operand addr, addr_wk!=0.
REQ-021 Buses SHALL be evaluated independently; at most one can match an operand, since the match includes the bus's producer tag.
REQ-022 Dispatch bypass: an operand dispatched in the same cycle as a matching bus write SHALL be stored UNLOCKED with the bus data.
REQ-023 An operand with addr==0 and a non-UNLOCKED tag SHALL be stored UNLOCKED with data 0.
REQ-024 An entry is ready when busy and both tags are UNLOCKED as currently stored; wakeup takes effect one cycle after the bus write.
REQ-025 Selection SHALL pick the lowest-index ready entry; iss_valid and iss_* SHALL be combinational from that entry; iss_* SHALL be 0 when iss_valid is low.
REQ-026 The selected entry SHALL be freed at the edge when rdy && iss_valid && iss_ready.
REQ-027 Free and dispatch in the same cycle SHALL be allowed; dispatch targets the lowest free entry before the free takes effect, so a freed slot is not reused until the next cycle.
REQ-028 Latency: a dispatch with both operands UNLOCKED SHALL give iss_valid in the next cycle if no lower-index entry is ready.
REQ-029 While iss_ready is low, iss_* SHALL stay stable unless a lower-index entry becomes ready.

Reset
REQ-030 On rst at an edge: all busy=0, tags=UNLOCKED, data/op/rd=0; full=0, iss_valid=0, iss_*=0 in the following cycle.
REQ-031 rst SHALL take priority over rdy and over any in-flight dispatch or issue in the same cycle.

Verification
REQ-032 Reset, then dispatch op=5, rd=3, x=10/UNLOCKED, y=20/UNLOCKED, iss_ready=1 -> next cycle iss_valid=1, iss_op=5, iss_rd=3, iss_x=10, iss_y=20; entry freed the cycle after.
REQ-033 Dispatch with tagx=ALU_MASTER, addrx=7; later en_w0=1, addr_w0=7, data_w0=0x55 -> iss_valid rises the cycle after the write with iss_x=0x55; an en_w1 write to reg 7 before it has no effect.
REQ-034 Hold iss_ready=0 and dispatch 4 entries -> full=1; a 5th dispatch is ignored; release iss_ready -> entries issue in index order 0..3, one per cycle.
REQ-035 Dispatch tagy=LOAD_STORE, addry=9 in the same cycle as en_w2=1, addr_w2=9, data_w2=0xABCD -> stored UNLOCKED with y=0xABCD; issues next cycle.
REQ-036 With 2 entries busy, rdy=0 for 3 cycles with bus writes, dispatches and iss_ready=1 -> no state change; assert rst mid-operation -> full=0, iss_valid=0 the next cycle.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU ops until both operands are
// available, snooping three result buses, and issues the lowest ready entry.
module alu_rs #(
    parameter int WORD   = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 2,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              disp_en,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [ADDR_W-1:0] disp_rd,
    input  logic [WORD-1:0]   disp_datax,
    input  logic [WORD-1:0]   disp_datay,
    input  logic [TAG_W-1:0]  disp_tagx,
    input  logic [TAG_W-1:0]  disp_tagy,
    input  logic [ADDR_W-1:0] disp_addrx,
    input  logic [ADDR_W-1:0] disp_addry,
    input  logic              en_w0,
    input  logic [ADDR_W-1:0] addr_w0,
    input  logic [WORD-1:0]   data_w0,
    input  logic              en_w1,
    input  logic [ADDR_W-1:0] addr_w1,
    input  logic [WORD-1:0]   data_w1,
    input  logic              en_w2,
    input  logic [ADDR_W-1:0] addr_w2,
    input  logic [WORD-1:0]   data_w2,
    output logic              full,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [OP_W-1:0]   iss_op,
    output logic [ADDR_W-1:0] iss_rd,
    output logic [WORD-1:0]   iss_x,
    output logic [WORD-1:0]   iss_y
);

    localparam logic [TAG_W-1:0] UNLOCKED   = TAG_W'(0);
    localparam logic [TAG_W-1:0] ALU_MASTER = TAG_W'(1);
    localparam logic [TAG_W-1:0] ALU_SALVER = TAG_W'(2);
    localparam logic [TAG_W-1:0] LOAD_STORE = TAG_W'(3);
    localparam int NBUS  = 3;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [WORD-1:0]   data;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
    } operand_t;

    logic [DEPTH-1:0]  busy;
    logic [OP_W-1:0]   op_q [DEPTH];
    logic [ADDR_W-1:0] rd_q [DEPTH];
    operand_t          opx  [DEPTH];
    operand_t          opy  [DEPTH];

    logic [NBUS-1:0]   w_en;
    logic [ADDR_W-1:0] w_addr [NBUS];
    logic [WORD-1:0]   w_data [NBUS];
    logic [TAG_W-1:0]  w_tag  [NBUS];

    logic [DEPTH-1:0]  ready;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              disp_fire;
    logic              iss_fire;

    assign w_en      = {en_w2, en_w1, en_w0};
    assign w_addr[0] = addr_w0;
    assign w_addr[1] = addr_w1;
    assign w_addr[2] = addr_w2;
    assign w_data[0] = data_w0;
    assign w_data[1] = data_w1;
    assign w_data[2] = data_w2;
    assign w_tag[0]  = ALU_MASTER;
    assign w_tag[1]  = ALU_SALVER;
    assign w_tag[2]  = LOAD_STORE;

    // Register 0 is hardwired zero, so a pending r0 operand resolves at once;
    // otherwise the bus whose producer tag matches supplies the value.
    function automatic operand_t resolve(input operand_t in);
        operand_t r;
        r = in;
        if (in.tag != UNLOCKED) begin
            if (in.addr == '0) begin
                r.tag  = UNLOCKED;
                r.data = '0;
            end else begin
                for (int k = 0; k < NBUS; k++) begin
                    if (w_en[k] && in.tag == w_tag[k] && w_addr[k] == in.addr) begin
                        r.tag  = UNLOCKED;
                        r.data = w_data[k];
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready[i] = busy[i] && (opx[i].tag == UNLOCKED) && (opy[i].tag == UNLOCKED);
            if (!busy[i]) free_idx = IDX_W'(i);
            if (ready[i]) sel_idx = IDX_W'(i);
        end
    end

    assign full      = &busy;
    assign iss_valid = |ready;
    assign disp_fire = rdy && disp_en && !full;
    assign iss_fire  = rdy && iss_valid && iss_ready;
    assign iss_op    = iss_valid ? op_q[sel_idx]     : '0;
    assign iss_rd    = iss_valid ? rd_q[sel_idx]     : '0;
    assign iss_x     = iss_valid ? opx[sel_idx].data : '0;
    assign iss_y     = iss_valid ? opy[sel_idx].data : '0;

    // The dispatch slot is chosen from the pre-free busy vector, so it never
    // collides with the entry being issued this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i] <= '0;
                rd_q[i] <= '0;
                opx[i]  <= '0;
                opy[i]  <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i]) begin
                    opx[i] <= resolve(opx[i]);
                    opy[i] <= resolve(opy[i]);
                end
            end
            if (iss_fire) busy[sel_idx] <= 1'b0;
            if (disp_fire) begin
                busy[free_idx] <= 1'b1;
                op_q[free_idx] <= disp_op;
                rd_q[free_idx] <= disp_rd;
                opx[free_idx]  <= resolve('{data: disp_datax, tag: disp_tagx, addr: disp_addrx});
                opy[free_idx]  <= resolve('{data: disp_datay, tag: disp_tagy, addr: disp_addry});
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: issue latency, bus wakeup and
// bypass, full handling, rdy stall and reset.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        disp_en = 1'b0;
    logic [5:0]  disp_op = '0;
    logic [4:0]  disp_rd = '0;
    logic [31:0] disp_datax = '0, disp_datay = '0;
    logic [1:0]  disp_tagx = '0, disp_tagy = '0;
    logic [4:0]  disp_addrx = '0, disp_addry = '0;
    logic        en_w0 = 1'b0, en_w1 = 1'b0, en_w2 = 1'b0;
    logic [4:0]  addr_w0 = '0, addr_w1 = '0, addr_w2 = '0;
    logic [31:0] data_w0 = '0, data_w1 = '0, data_w2 = '0;
    logic        full, iss_valid;
    logic        iss_ready = 1'b0;
    logic [5:0]  iss_op;
    logic [4:0]  iss_rd;
    logic [31:0] iss_x, iss_y;

    int checks = 0;
    int errors = 0;

    alu_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_en(disp_en), .disp_op(disp_op), .disp_rd(disp_rd),
        .disp_datax(disp_datax), .disp_datay(disp_datay),
        .disp_tagx(disp_tagx), .disp_tagy(disp_tagy),
        .disp_addrx(disp_addrx), .disp_addry(disp_addry),
        .en_w0(en_w0), .addr_w0(addr_w0), .data_w0(data_w0),
        .en_w1(en_w1), .addr_w1(addr_w1), .data_w1(data_w1),
        .en_w2(en_w2), .addr_w2(addr_w2), .data_w2(data_w2),
        .full(full), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_rd(iss_rd), .iss_x(iss_x), .iss_y(iss_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [5:0] op, input logic [4:0] rd,
                                 input logic [31:0] x, input logic [1:0] tx, input logic [4:0] ax,
                                 input logic [31:0] y, input logic [1:0] ty, input logic [4:0] ay);
        disp_en    = en;
        disp_op    = op;
        disp_rd    = rd;
        disp_datax = x;
        disp_tagx  = tx;
        disp_addrx = ax;
        disp_datay = y;
        disp_tagy  = ty;
        disp_addry = ay;
    endtask

    task automatic noDispatch();
        applyStimulus(1'b0, '0, '0, '0, 2'd0, '0, '0, 2'd0, '0);
    endtask

    initial begin
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("reset_full", {31'd0, full}, 32'd0);
        checkOutput("reset_valid", {31'd0, iss_valid}, 32'd0);
        checkOutput("reset_op", {26'd0, iss_op}, 32'd0);
        checkOutput("reset_x", iss_x, 32'd0);

        // Ready-at-dispatch: issues the next cycle, freed the one after
        iss_ready = 1'b1;
        applyStimulus(1'b1, 6'd5, 5'd3, 32'd10, 2'd0, 5'd1, 32'd20, 2'd0, 5'd2);
        tick();
        noDispatch();
        checkOutput("basic_valid", {31'd0, iss_valid}, 32'd1);
        checkOutput("basic_op", {26'd0, iss_op}, 32'd5);
        checkOutput("basic_rd", {27'd0, iss_rd}, 32'd3);
        checkOutput("basic_x", iss_x, 32'd10);
        checkOutput("basic_y", iss_y, 32'd20);
        tick();
        checkOutput("basic_freed", {31'd0, iss_valid}, 32'd0);
        checkOutput("basic_rd_zero", {27'd0, iss_rd}, 32'd0);

        // Wakeup on bus 0 only; wrong-tag bus 1 write is ignored
        applyStimulus(1'b1, 6'd7, 5'd4, 32'h11, 2'd1, 5'd7, 32'd2, 2'd0, 5'd0);
        tick();
        noDispatch();
        checkOutput("wake_wait", {31'd0, iss_valid}, 32'd0);
        en_w1 = 1'b1; addr_w1 = 5'd7; data_w1 = 32'h99;
        tick();
        en_w1 = 1'b0;
        checkOutput("wake_wrongbus", {31'd0, iss_valid}, 32'd0);
        en_w0 = 1'b1; addr_w0 = 5'd7; data_w0 = 32'h55;
        tick();
        en_w0 = 1'b0;
        checkOutput("wake_valid", {31'd0, iss_valid}, 32'd1);
        checkOutput("wake_x", iss_x, 32'h55);
        checkOutput("wake_y", iss_y, 32'd2);
        tick();
        checkOutput("wake_freed", {31'd0, iss_valid}, 32'd0);

        // Pending operand on r0 resolves to zero immediately
        applyStimulus(1'b1, 6'd9, 5'd1, 32'h77, 2'd2, 5'd0, 32'd3, 2'd0, 5'd0);
        tick();
        noDispatch();
        checkOutput("r0_valid", {31'd0, iss_valid}, 32'd1);
        checkOutput("r0_x", iss_x, 32'd0);
        tick();

        // Fill all four entries while the ALU stalls
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 6'(i + 1), 5'(i), 32'(i * 16), 2'd0, 5'd1, 32'(i), 2'd0, 5'd2);
            tick();
            if (i == 2) checkOutput("fill_not_full", {31'd0, full}, 32'd0);
        end
        checkOutput("fill_full", {31'd0, full}, 32'd1);
        checkOutput("fill_head_op", {26'd0, iss_op}, 32'd1);
        applyStimulus(1'b1, 6'h3F, 5'd31, 32'hFFFF, 2'd0, 5'd1, 32'hFFFF, 2'd0, 5'd2);
        tick();
        noDispatch();
        checkOutput("overflow_full", {31'd0, full}, 32'd1);
        checkOutput("overflow_stable_op", {26'd0, iss_op}, 32'd1);
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain%0d_op", i), {26'd0, iss_op}, 32'(i + 1));
            checkOutput($sformatf("drain%0d_x", i), iss_x, 32'(i * 16));
            tick();
        end
        checkOutput("drain_empty", {31'd0, iss_valid}, 32'd0);
        checkOutput("drain_not_full", {31'd0, full}, 32'd0);

        // Same-cycle bypass from bus 2
        iss_ready = 1'b0;
        applyStimulus(1'b1, 6'h2A, 5'd5, 32'd1, 2'd0, 5'd0, 32'hDEAD, 2'd3, 5'd9);
        en_w2 = 1'b1; addr_w2 = 5'd9; data_w2 = 32'hABCD;
        tick();
        noDispatch();
        en_w2 = 1'b0;
        checkOutput("bypass_valid", {31'd0, iss_valid}, 32'd1);
        checkOutput("bypass_y", iss_y, 32'hABCD);
        checkOutput("bypass_op", {26'd0, iss_op}, 32'h2A);
        iss_ready = 1'b1;
        tick();
        checkOutput("bypass_freed", {31'd0, iss_valid}, 32'd0);

        // rdy stall: entry 0 ready, entry 1 waits on r6 from bus 0
        iss_ready = 1'b0;
        applyStimulus(1'b1, 6'h11, 5'd2, 32'hA, 2'd0, 5'd1, 32'hB, 2'd0, 5'd2);
        tick();
        applyStimulus(1'b1, 6'h12, 5'd3, 32'h0, 2'd1, 5'd6, 32'hC, 2'd0, 5'd2);
        tick();
        rdy = 1'b0;
        iss_ready = 1'b1;
        applyStimulus(1'b1, 6'h13, 5'd4, 32'h1, 2'd0, 5'd1, 32'h2, 2'd0, 5'd2);
        en_w0 = 1'b1; addr_w0 = 5'd6; data_w0 = 32'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_op", i), {26'd0, iss_op}, 32'h11);
            checkOutput($sformatf("stall%0d_full", i), {31'd0, full}, 32'd0);
        end
        rdy = 1'b1;
        noDispatch();
        en_w0 = 1'b0;
        tick();
        checkOutput("stall_wake_ignored", {31'd0, iss_valid}, 32'd0);

        // Reset wins over a simultaneous dispatch and issue
        applyStimulus(1'b1, 6'h14, 5'd5, 32'h3, 2'd0, 5'd1, 32'h4, 2'd0, 5'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        noDispatch();
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_valid", {31'd0, iss_valid}, 32'd0);
        checkOutput("rst_op", {26'd0, iss_op}, 32'd0);
        tick();
        checkOutput("rst_no_dispatch", {31'd0, iss_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
